// File: rtl/mips_defs.sv
// Shared register-file definitions for the integer pipeline.
// Widths and the hardwired-zero register index.
package mips_defs;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_aux_fifo.sv
// Small synchronous FIFO buffering out-of-order aux results.
// Caller guarantees no push when full and no pop when empty.
module wb_aux_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic          full,
  output logic          empty,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;

  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipe and buffered aux results onto the
// register-file write port, with a starvation guard for aux.
module wb_arbiter
  import mips_defs::*;
#(
  parameter int DATA_W = mips_defs::DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int AUX_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_stall,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [ADDR_W-1:0] aux_waddr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_pending,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);
  localparam int CW = $clog2(AUX_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int EW = ADDR_W + DATA_W;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              force_aux;
  logic              take_pipe;
  logic [EW-1:0]     head;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  wb_aux_fifo #(
    .W    (EW),
    .DEPTH(AUX_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  ({aux_waddr, aux_wdata}),
    .full (full),
    .empty(empty),
    .head (head),
    .count(count)
  );

  assign {head_addr, head_data} = head;

  assign force_aux   = starve == SW'(STARVE_MAX);
  assign aux_ready   = rst & ~full;
  assign aux_pending = count != '0;
  assign push        = aux_valid & aux_ready;
  assign pop         = rst & ~empty
                     & (force_aux | ~pipe_valid);
  assign take_pipe   = rst & pipe_valid & ~pop;
  // A pop while pipe is valid only happens when aux is forced.
  assign pipe_stall  = pipe_valid & pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve <= '0;
    end else if (pop || empty) begin
      starve <= '0;
    end else if (take_pipe && !force_aux) begin
      starve <= starve + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      unique case (1'b1)
        pop: begin
          we    <= head_addr != ADDR_W'(REG_ZERO);
          waddr <= head_addr;
          wdata <= head_data;
        end
        take_pipe: begin
          we    <= pipe_waddr != ADDR_W'(REG_ZERO);
          waddr <= pipe_waddr;
          wdata <= pipe_wdata;
        end
        default: we <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a queue-based model.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_waddr = '0;
  logic [31:0] pipe_wdata = '0;
  logic        pipe_stall;
  logic        aux_valid = 1'b0;
  logic        aux_ready;
  logic [4:0]  aux_waddr = '0;
  logic [31:0] aux_wdata = '0;
  logic        aux_pending;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  wb_arbiter #(
    .DATA_W(32), .ADDR_W(5),
    .AUX_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_waddr(pipe_waddr),
    .pipe_wdata(pipe_wdata), .pipe_stall(pipe_stall),
    .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
    .aux_pending(aux_pending),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          ms = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  logic        e_rdy, e_stall, e_pend;
  logic        s_rdy, s_stall, s_pend;
  int          npass = 0;
  int          ntot = 0;

  // One clock: sample comb outputs, advance model, land at posedge+1.
  task automatic tick();
    bit   pend, frc;
    ent_t h;
    @(negedge clk);
    s_rdy   = aux_ready;
    s_stall = pipe_stall;
    s_pend  = aux_pending;
    pend    = mq.size() > 0;
    frc     = ms == SMAX;
    e_rdy   = rst && mq.size() < DEPTH;
    e_pend  = pend;
    e_stall = rst && frc && pend && pipe_valid;
    if (!rst) begin
      mq.delete();
      ms = 0; m_we = 0; m_wa = '0; m_wd = '0;
    end else begin
      if (pend && (frc || !pipe_valid)) begin
        h = mq.pop_front();
        m_we = h.a != 0; m_wa = h.a; m_wd = h.d;
        ms = 0;
      end else if (pipe_valid) begin
        m_we = pipe_waddr != 0;
        m_wa = pipe_waddr; m_wd = pipe_wdata;
        ms = pend ? ((ms < SMAX) ? ms + 1 : SMAX) : 0;
      end else begin
        m_we = 0;
      end
      if (aux_valid && e_rdy)
        mq.push_back('{aux_waddr, aux_wdata});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0; aux_valid = 1; pipe_valid = 1;
    aux_waddr = 5'd9; pipe_waddr = 5'd4;
    tick(); tick();
    ntot++;
    if (s_rdy !== 1'b0)
      $display("FAIL reset_ready got=%b want=0", s_rdy);
    else npass++;
    ntot++;
    if (s_stall !== 1'b0)
      $display("FAIL reset_stall got=%b want=0", s_stall);
    else npass++;
    ntot++;
    if ({we, waddr, wdata} !== 38'd0)
      $display("FAIL reset_out got=%b/%h/%h want=0",
               we, waddr, wdata);
    else npass++;
    aux_valid = 0; pipe_valid = 0;
    rst = 1;
    #1;
    ntot++;
    if (aux_ready !== 1'b1)
      $display("FAIL release_ready got=%b want=1", aux_ready);
    else npass++;
  endtask

  task automatic test_pipe_single();
    pipe_valid = 1; pipe_waddr = 5'd3; pipe_wdata = 32'h11;
    tick();
    pipe_valid = 0;
    ntot++;
    if ({we, waddr, wdata} !== {1'b1, 5'd3, 32'h11})
      $display("FAIL pipe_write got=%b/%h/%h want=1/03/11",
               we, waddr, wdata);
    else npass++;
    tick();
    ntot++;
    if (we !== 1'b0)
      $display("FAIL pipe_once got=%b want=0", we);
    else npass++;
  endtask

  task automatic test_aux_b2b();
    aux_valid = 1; aux_waddr = 5'd5; aux_wdata = 32'hA5;
    tick();
    aux_waddr = 5'd6; aux_wdata = 32'hB6;
    tick();
    aux_valid = 0;
    ntot++;
    if ({we, waddr, wdata} !== {1'b1, 5'd5, 32'hA5})
      $display("FAIL aux_first got=%b/%h/%h want=1/05/a5",
               we, waddr, wdata);
    else npass++;
    tick();
    ntot++;
    if ({we, waddr, wdata} !== {1'b1, 5'd6, 32'hB6})
      $display("FAIL aux_second got=%b/%h/%h want=1/06/b6",
               we, waddr, wdata);
    else npass++;
    ntot++;
    if (aux_pending !== 1'b0)
      $display("FAIL aux_drained got=%b want=0", aux_pending);
    else npass++;
  endtask

  task automatic test_starvation();
    logic [4:0] head_a;
    pipe_valid = 1;
    aux_valid = 1;
    for (int i = 0; i < 2; i++) begin
      pipe_waddr = 5'($urandom_range(1, 31));
      pipe_wdata = $urandom;
      aux_waddr  = 5'(7 + i);
      aux_wdata  = $urandom;
      tick();
    end
    aux_valid = 0;
    head_a = 5'd7;
    for (int i = 0; i < 6; i++) begin
      pipe_waddr = 5'($urandom_range(1, 31));
      pipe_wdata = $urandom;
      tick();
      ntot++;
      if (s_stall !== (i == 3) || s_stall !== e_stall)
        $display("FAIL starve_stall[%0d] got=%b want=%b",
                 i, s_stall, (i == 3));
      else npass++;
      ntot++;
      if (s_rdy !== (i > 3) || s_rdy !== e_rdy)
        $display("FAIL starve_ready[%0d] got=%b want=%b",
                 i, s_rdy, (i > 3));
      else npass++;
      ntot++;
      if (we !== m_we || waddr !== m_wa || wdata !== m_wd
          || (i == 3 && waddr !== head_a))
        $display("FAIL starve_out[%0d] got=%b/%h/%h want=%b/%h/%h",
                 i, we, waddr, wdata, m_we, m_wa, m_wd);
      else npass++;
    end
    pipe_valid = 0;
    tick();
    ntot++;
    if ({we, waddr} !== {1'b1, 5'd8} || wdata !== m_wd)
      $display("FAIL starve_drain got=%b/%h/%h want=1/08/%h",
               we, waddr, wdata, m_wd);
    else npass++;
    tick();
  endtask

  task automatic test_reg0();
    pipe_valid = 1; pipe_waddr = 5'd0; pipe_wdata = 32'hFF;
    tick();
    pipe_valid = 0;
    ntot++;
    if (s_stall !== 1'b0)
      $display("FAIL reg0_stall got=%b want=0", s_stall);
    else npass++;
    ntot++;
    if ({we, waddr, wdata} !== {1'b0, 5'd0, 32'hFF})
      $display("FAIL reg0_out got=%b/%h/%h want=0/00/ff",
               we, waddr, wdata);
    else npass++;
  endtask

  task automatic test_reset_flush();
    pipe_valid = 1; pipe_waddr = 5'd2; pipe_wdata = 32'h22;
    aux_valid = 1;
    for (int i = 0; i < 2; i++) begin
      aux_waddr = 5'(12 + i); aux_wdata = $urandom;
      tick();
    end
    aux_valid = 0; pipe_valid = 0;
    rst = 0;
    tick();
    rst = 1;
    #1;
    ntot++;
    if (aux_pending !== 1'b0)
      $display("FAIL flush_pending got=%b want=0", aux_pending);
    else npass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      ntot++;
      if (we !== 1'b0)
        $display("FAIL flush_nowrite[%0d] got=%b want=0", i, we);
      else npass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      if (!(s_stall && pipe_valid)) begin
        pipe_valid = ($urandom_range(0, 3) != 0);
        pipe_waddr = 5'($urandom);
        pipe_wdata = $urandom;
      end
      aux_valid = ($urandom_range(0, 2) == 0);
      aux_waddr = 5'($urandom);
      aux_wdata = $urandom;
      tick();
      ntot++;
      if (s_rdy !== e_rdy || s_stall !== e_stall || s_pend !== e_pend)
        $display("FAIL rand_flags[%0d] got=%b%b%b want=%b%b%b",
                 i, s_rdy, s_stall, s_pend, e_rdy, e_stall, e_pend);
      else npass++;
      ntot++;
      if (we !== m_we || (m_we && (waddr !== m_wa || wdata !== m_wd)))
        $display("FAIL rand_out[%0d] got=%b/%h/%h want=%b/%h/%h",
                 i, we, waddr, wdata, m_we, m_wa, m_wd);
      else npass++;
    end
    rst = 1; pipe_valid = 0; aux_valid = 0;
  endtask

  initial begin
    s_stall = 0;
    test_reset();
    test_pipe_single();
    test_aux_b2b();
    test_starvation();
    test_reg0();
    test_reset_flush();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
